// File: rtl/mandelbrot_iterator.sv
// Iterates z <- z^2 + c in signed fixed point until |z|^2 exceeds 4.0 or the
// iteration limit is reached, then holds the result until it is consumed.
module mandelbrot_iterator #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 28,
  parameter int ITER_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
  input  logic [ITER_W-1:0]       max_iter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ITER_W-1:0]       iter_count,
  output logic                    escaped,
  output logic signed [WIDTH-1:0] z_re,
  output logic signed [WIDTH-1:0] z_im,
  output logic                    busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // 4.0 at product scale (2*FRAC fraction bits), one guard bit above 2*WIDTH.
  localparam logic [2*WIDTH:0] ESC_LIMIT =
    {{(2*WIDTH-2){1'b0}}, 3'b100} << (2*FRAC);

  logic [1:0]              state;
  logic signed [WIDTH-1:0] cr_q;
  logic signed [WIDTH-1:0] ci_q;
  logic [ITER_W-1:0]       m_q;
  logic [ITER_W-1:0]       n_q;

  logic signed [2*WIDTH-1:0] aa;
  logic signed [2*WIDTH-1:0] bb;
  logic signed [2*WIDTH-1:0] ab;
  logic signed [2*WIDTH-1:0] diff;
  logic signed [2*WIDTH-1:0] dbl;
  logic [2*WIDTH:0]          mag;
  logic                      escape;
  logic signed [WIDTH-1:0]   next_re;
  logic signed [WIDTH-1:0]   next_im;

  assign aa   = z_re * z_re;
  assign bb   = z_im * z_im;
  assign ab   = z_re * z_im;
  assign diff = aa - bb;
  assign dbl  = ab <<< 1;

  // Squares are non-negative, so a zero-extended sum cannot overflow.
  assign mag    = {1'b0, aa} + {1'b0, bb};
  assign escape = mag > ESC_LIMIT;

  assign next_re = WIDTH'(diff >>> FRAC) + cr_q;
  assign next_im = WIDTH'(dbl >>> FRAC) + ci_q;

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign iter_count = n_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cr_q    <= '0;
      ci_q    <= '0;
      m_q     <= '0;
      n_q     <= '0;
      escaped <= 1'b0;
      z_re    <= '0;
      z_im    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cr_q    <= c_re;
            ci_q    <= c_im;
            m_q     <= max_iter;
            n_q     <= '0;
            escaped <= 1'b0;
            z_re    <= '0;
            z_im    <= '0;
            state   <= ITER;
          end
        end
        ITER: begin
          if (escape) begin
            escaped <= 1'b1;
            state   <= DONE;
          end else if (n_q == m_q) begin
            state <= DONE;
          end else begin
            z_re <= next_re;
            z_im <= next_im;
            n_q  <= n_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
